// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, stage state encoding and opcode legality helper
package alu_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam int OP_W      = 3;

    localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [OP_W-1:0] ALU_SRL = 3'b100;
    localparam logic [OP_W-1:0] ALU_SRA = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_WB   = 2'b10
    } state_e;

    // Ops 110 and 111 are unassigned and must never reach the register file
    function automatic logic OP_LEGAL(input logic [OP_W-1:0] op);
        return op <= ALU_SRA;
    endfunction

endpackage

// File: rtl/grf.sv
// rtl/grf.sv - general register file: two async read ports, debug read port, one sync write port, r0 reads zero
module grf
    import alu_pkg::*;
#(
    parameter int RF_DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] raddr_a,
    input  logic [REG_IDX_W-1:0] raddr_b,
    input  logic [REG_IDX_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]    rdata_a,
    output logic [DATA_W-1:0]    rdata_b,
    output logic [DATA_W-1:0]    dbg_data,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata
);

    logic [DATA_W-1:0] mem_q [RF_DEPTH];
    logic [DATA_W-1:0] mem_d [RF_DEPTH];

    // Next-state of the array: a single write per cycle, r0 and out-of-range indices never stored
    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != '0) && (int'(waddr) < RF_DEPTH)) begin
            mem_d[waddr] = wdata;
        end
    end

    // Array storage; asynchronous reset clears every entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read ports: index 0 and unimplemented indices return zero
    always_comb begin
        rdata_a  = '0;
        rdata_b  = '0;
        dbg_data = '0;
        if ((raddr_a != '0) && (int'(raddr_a) < RF_DEPTH)) begin
            rdata_a = mem_q[raddr_a];
        end
        if ((raddr_b != '0) && (int'(raddr_b) < RF_DEPTH)) begin
            rdata_b = mem_q[raddr_b];
        end
        if ((dbg_addr != '0) && (int'(dbg_addr) < RF_DEPTH)) begin
            dbg_data = mem_q[dbg_addr];
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - operand fetch / ALU sequencing / write-back stage; OPSTAGE_IMM_EN adds the immediate B source
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int RF_DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W-1:0]      in_op,
    input  logic [REG_IDX_W-1:0] in_rs,
    input  logic [REG_IDX_W-1:0] in_rt,
    input  logic [REG_IDX_W-1:0] in_rd,
`ifdef OPSTAGE_IMM_EN
    input  logic                 in_imm_sel,
    input  logic [15:0]          in_imm,
`endif
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [OP_W-1:0]      alu_op,
    input  logic [DATA_W-1:0]    alu_c,
    output logic                 wb_valid,
    output logic [REG_IDX_W-1:0] wb_addr,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 illegal,
    input  logic [REG_IDX_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]    dbg_data
);

    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      a_q, a_d;
    logic [DATA_W-1:0]      b_q, b_d;
    logic [OP_W-1:0]        op_q, op_d;
    logic [REG_IDX_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0]      res_q, res_d;
    logic                   wb_valid_q, wb_valid_d;
    logic [REG_IDX_W-1:0]   wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]      wb_data_q, wb_data_d;
    logic                   illegal_q, illegal_d;

    logic [DATA_W-1:0]      rf_rs;
    logic [DATA_W-1:0]      rf_rt;
    logic [DATA_W-1:0]      b_src;
    logic                   rf_we;

    grf #(
        .RF_DEPTH (RF_DEPTH)
    ) u_grf (
        .clk      (clk),
        .reset    (reset),
        .raddr_a  (in_rs),
        .raddr_b  (in_rt),
        .dbg_addr (dbg_addr),
        .rdata_a  (rf_rs),
        .rdata_b  (rf_rt),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .waddr    (rd_q),
        .wdata    (res_q)
    );

`ifdef OPSTAGE_IMM_EN
    // B source: add/sub sign-extend the immediate, logic ops and shifts zero-extend it
    always_comb begin
        b_src = rf_rt;
        if (in_imm_sel) begin
            if ((in_op == ALU_ADD) || (in_op == ALU_SUB)) begin
                b_src = {{16{in_imm[15]}}, in_imm};
            end else begin
                b_src = {16'h0000, in_imm};
            end
        end
    end
`else
    // B source: always the rt register
    always_comb begin
        b_src = rf_rt;
    end
`endif

    // Next-state and registered-output logic for the IDLE -> EXEC -> WB sequence
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        rd_d       = rd_q;
        res_d      = res_q;
        wb_valid_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        illegal_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = rf_rs;
                    b_d     = b_src;
                    op_d    = in_op;
                    rd_d    = in_rd;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Pulses are set here so they are registered and visible exactly during S_WB
                res_d      = alu_c;
                wb_valid_d = OP_LEGAL(op_q);
                illegal_d  = !OP_LEGAL(op_q);
                if (OP_LEGAL(op_q)) begin
                    wb_addr_d = rd_q;
                    wb_data_d = (rd_q == '0) ? '0 : alu_c;
                end
                state_d = S_WB;
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stage state; asynchronous reset aborts any in-flight write-back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            res_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            res_q      <= res_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            illegal_q  <= illegal_d;
        end
    end

    // Register-file write happens on the edge that leaves S_WB
    always_comb begin
        rf_we = (state_q == S_WB) && OP_LEGAL(op_q) && (rd_q != '0);
    end

    assign in_ready = (state_q == S_IDLE);
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_op   = op_q;
    assign wb_valid = wb_valid_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign illegal  = illegal_q;

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand-fetch, sequencing and write-back stage that sits directly upstream of the combinational `alu`. It accepts one register-register (or register-immediate) instruction token per transaction over a valid/ready handshake and reads both operands from its internal 32×32 general register file. It drives `A`, `B` and `ALUOp` into the ALU, captures `C` on the following cycle and writes it back to the destination register.

## Interface
Parameters:
- `RF_DEPTH`, 32: number of general registers; register 0 is hardwired to zero.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: instruction token is valid.
- `in_ready` output 1: stage can accept a token.
- `in_op` input 3: ALU operation, passed through unchanged as `ALUOp`.
- `in_rs`, `in_rt`, `in_rd` input 5 each: source A, source B and destination register indices.
- `in_imm_sel` input 1: B comes from the immediate instead of `rf[rt]`. Present only with `OPSTAGE_IMM_EN`.
- `in_imm` input 16: immediate value. Present only with `OPSTAGE_IMM_EN`.
- `alu_a`, `alu_b` output 32 each: operands to the ALU.
- `alu_op` output 3: operation to the ALU.
- `alu_c` input 32: ALU result.
- `wb_valid` output 1: one-cycle pulse marking a completed write-back.
- `wb_addr` output 5: destination register index.
- `wb_data` output 32: value written.
- `illegal` output 1: one-cycle pulse flagging an unsupported op.
- `dbg_addr` input 5: debug read index.
- `dbg_data` output 32: combinational read of `rf[dbg_addr]`; returns 0 for index 0.

## Operation
- FSM states are S_IDLE, S_EXEC and S_WB. The encoding is 2 bits and the reset state is S_IDLE.
- **S_IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, latch op and rd, then read `rf[rs]` into the A register and `rf[rt]` (or the extended immediate) into the B register.
  - Go to S_EXEC.
- **S_EXEC**
  - `in_ready`=0.
  - `alu_a`/`alu_b`/`alu_op` show the latched values.
  - Capture `alu_c` into the result register and go to S_WB.
- **S_WB**
  - `in_ready`=0.
  - If op ≤ 3'b101, write `rf[rd]` = result, unless rd=0, in which case nothing is written.
  - `wb_valid`=1 with `wb_addr`=rd and `wb_data`=result. When rd=0, `wb_data` is forced to 0.
  - If op is 3'b110 or 3'b111: no write, `wb_valid`=0, `illegal`=1.
  - Go to S_IDLE.
- **Valid ops:** 000 add, 001 sub, 010 and, 011 or, 100 logical right shift, 101 arithmetic right shift. All arithmetic is 32-bit and wraps; the ALU performs it.
- **Read-after-write:** transactions are serialized, so a token's operand read always sees the previous token's write. No bypass is needed.
- `alu_a`, `alu_b` and `alu_op` hold their last values outside S_EXEC. They are not cleared.
- **Reset** is asynchronous and may arrive mid-operation:
  - State returns to S_IDLE and any in-flight write is aborted.
  - All registers, `alu_a`, `alu_b`, `alu_op`, `wb_addr`, `wb_data`, `wb_valid` and `illegal` reset to 0.
  - `in_ready` is 1 during and after reset.

## Timing
- Accept edge n, EXEC cycle n+1, write-back on edge n+2. The new value is visible on `dbg_data` in cycle n+2+.
- Throughput is one token per 3 cycles, and `in_ready` is high one cycle in three under continuous load.
- The ALU path budget is one full cycle: registered operands → `alu` → `alu_c` → result register.
- `wb_valid` and `illegal` are high for exactly one cycle, during S_WB.
- `in_valid` while `in_ready`=0 is ignored; the upstream holds the token.

## Configuration
- `OPSTAGE_IMM_EN` defined:
  - `in_imm_sel` and `in_imm` exist.
  - Ops 000 and 001 sign-extend the immediate.
  - Ops 010–101 zero-extend it.
  - Shifts use the full 32-bit B value.
- `OPSTAGE_IMM_EN` undefined: both ports are absent and B is always `rf[rt]`.

## Structure
- Shared package `alu_pkg`:
  - ALUOp localparams (ALU_ADD … ALU_SRA).
  - State encoding.
  - Register-index width.
  - The `OP_LEGAL` function (op ≤ 5).
- Sub-module `grf`, the register file:
  - Two combinational read ports plus a debug read port.
  - One synchronous write port.
  - Asynchronous reset clears all entries.
  - Register 0 reads 0.

## Test plan
- **Reset mid-WB:** issue add rd=3 and assert `reset` during S_WB. Required: `rf[3]`=0, state S_IDLE, all outputs 0.
- **Seed and add:**
  - Seed r1=7 and r2=5 with immediate tokens (or by prior ops).
  - Issue op=000 rs=1 rt=2 rd=4.
  - Required: `wb_valid` at n+2, `wb_data`=12, `dbg_data`(4)=12.
- **Sub wrap-around:** r1=0, r2=1, op=001, rd=5. Required: r5=32'hFFFF_FFFF.
- **Arithmetic shift:** r6=32'h8000_0000, r7=4, op=101. Required: 32'hF800_0000. With op=100, required: 32'h0800_0000.
- **Back-to-back and rd=0:**
  - Issue back-to-back dependent tokens: r8 = r1+r1, then r9 = r8+r8 with r1=3. Required: r9=12 and `in_ready` pattern 1,0,0,1.
  - rd=0 write: required `rf[0]` stays 0.
- **Illegal op:** op=110. Required: `illegal` one-cycle pulse, `wb_valid`=0, no register changes. With `OPSTAGE_IMM_EN`, imm=16'hFFFF with op=000 gives 32'hFFFF_FFFF added, and with op=011 gives 32'h0000_FFFF OR'd.
